// File: rtl/la_ioring_cfg.sv
// la_ioring_cfg: serial configuration controller for the IO ring.
// Accepts a chain image, shifts it bit 0 first into the daisy-chained pad
// cells on ring_out[0] (sdata) and ring_out[1] (sclk), then pulses
// ring_out[2] (update) so every cell applies the new image together.
// The bits coming back from the chain end (ring_in[3]) are collected and
// returned on rsp_data, which gives the previous chain contents.
//
// Ports:
//   clk, nreset              core clock, async active-low reset
//   req_valid/req_ready      chain image handshake, req_data = image
//   rsp_valid/rsp_ready      completion handshake, rsp_data = readback
//   ring_out                 [0] sdata, [1] sclk, [2] update, upper bits 0
//   ring_in                  ring return, only [3] is used
//
// Build option: LA_IORING_CFG_READBACK_EN enables the readback capture;
// without it rsp_data is tied to 0 and ring_in is unused.
module la_ioring_cfg #(
    parameter int unsigned CHAINW = 64,
    parameter int unsigned CLKDIV = 4,
    parameter int unsigned RINGW  = 8
) (
    input  logic              clk,
    input  logic              nreset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [CHAINW-1:0] req_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [CHAINW-1:0] rsp_data,
    output logic [RINGW-1:0]  ring_out,
    input  logic [RINGW-1:0]  ring_in
);

    localparam int unsigned DW = $clog2(CLKDIV + 1);
    localparam int unsigned BW = $clog2(CHAINW + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SLO,
        ST_SHI,
        ST_UPD,
        ST_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [DW-1:0]     divcnt_q, divcnt_d;
    logic [BW-1:0]     bitcnt_q, bitcnt_d;
    logic [CHAINW-1:0] shreg_q, shreg_d;
    logic              sdata_q, sdata_d;
    logic              sclk_q, sclk_d;
    logic              upd_q, upd_d;
    logic              req_ready_q, req_ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              phase_end;

    // Only ring_in[3] matters; fold the whole bus here so it counts as used.
    logic unused_ring;
    assign unused_ring = ^ring_in;

`ifdef LA_IORING_CFG_READBACK_EN
    logic [CHAINW-1:0] rdbk_q, rdbk_d;
    logic [CHAINW-1:0] rsp_data_q, rsp_data_d;
`endif

    // State and output registers.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q     <= ST_IDLE;
            divcnt_q    <= '0;
            bitcnt_q    <= '0;
            shreg_q     <= '0;
            sdata_q     <= 1'b0;
            sclk_q      <= 1'b0;
            upd_q       <= 1'b0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
`ifdef LA_IORING_CFG_READBACK_EN
            rdbk_q      <= '0;
            rsp_data_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            divcnt_q    <= divcnt_d;
            bitcnt_q    <= bitcnt_d;
            shreg_q     <= shreg_d;
            sdata_q     <= sdata_d;
            sclk_q      <= sclk_d;
            upd_q       <= upd_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
`ifdef LA_IORING_CFG_READBACK_EN
            rdbk_q      <= rdbk_d;
            rsp_data_q  <= rsp_data_d;
`endif
        end
    end

    // Next state, counters, shift/capture, and next output values.
    always_comb begin
        state_d   = state_q;
        divcnt_d  = divcnt_q;
        bitcnt_d  = bitcnt_q;
        shreg_d   = shreg_q;
        phase_end = (divcnt_q == DW'(CLKDIV - 1));
`ifdef LA_IORING_CFG_READBACK_EN
        rdbk_d    = rdbk_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready_q) begin
                    shreg_d  = req_data;
                    bitcnt_d = '0;
                    divcnt_d = '0;
                    state_d  = ST_SLO;
                end
            end
            ST_SLO: begin
                if (phase_end) begin
                    divcnt_d = '0;
                    state_d  = ST_SHI;
`ifdef LA_IORING_CFG_READBACK_EN
                    // Chain end is sampled just before this bit's sclk rise.
                    for (int unsigned i = 0; i < CHAINW; i++) begin
                        if (BW'(i) == bitcnt_q) begin
                            rdbk_d[i] = ring_in[3];
                        end
                    end
`endif
                end else begin
                    divcnt_d = divcnt_q + DW'(1);
                end
            end
            ST_SHI: begin
                if (phase_end) begin
                    divcnt_d = '0;
                    shreg_d  = shreg_q >> 1;
                    bitcnt_d = bitcnt_q + BW'(1);
                    state_d  = (bitcnt_q == BW'(CHAINW - 1)) ? ST_UPD : ST_SLO;
                end else begin
                    divcnt_d = divcnt_q + DW'(1);
                end
            end
            ST_UPD: begin
                if (phase_end) begin
                    divcnt_d = '0;
                    state_d  = ST_DONE;
                end else begin
                    divcnt_d = divcnt_q + DW'(1);
                end
            end
            ST_DONE: begin
                if (rsp_valid_q && rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Outputs are registered from the next state so they align with it.
        sdata_d     = ((state_d == ST_SLO) || (state_d == ST_SHI)) ? shreg_d[0] : 1'b0;
        sclk_d      = (state_d == ST_SHI);
        upd_d       = (state_d == ST_UPD);
        req_ready_d = (state_d == ST_IDLE);
        rsp_valid_d = (state_d == ST_DONE);
`ifdef LA_IORING_CFG_READBACK_EN
        rsp_data_d  = (state_d == ST_DONE) ? rdbk_d : '0;
`endif
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign ring_out  = {(RINGW - 3)'(0), upd_q, sclk_q, sdata_q};

`ifdef LA_IORING_CFG_READBACK_EN
    assign rsp_data = rsp_data_q;
`else
    assign rsp_data = '0;
`endif

endmodule

// File: doc/la_ioring_cfg.md
# la_ioring_cfg

Ring-side configuration controller for the IO ring. It takes a full chain image from core logic and shifts it serially around the `ioring` bus into the daisy-chained pad cells, then pulses an update strobe so all cells apply it together. It also captures the bits returning from the end of the chain, so the previous chain contents read back. The block sits in the core power domain next to the padring and drives the ring lines that every IO cell taps.

## Interface
- `CHAINW`, 64: total configuration bits in the pad chain; must be ≥1.
- `CLKDIV`, 4: `clk` cycles per `sclk` half-period; must be ≥1.
- `RINGW`, 8: width of the IO ring bus; must be ≥4.

- `clk`  in  1  core clock.
- `nreset`  in  1  asynchronous active-low reset.
- `req_valid`  in  1  chain image is valid.
- `req_ready`  out  1  controller is idle and can accept a chain image.
- `req_data`  in  CHAINW  chain image; bit 0 is shifted first.
- `rsp_valid`  out  1  operation is complete.
- `rsp_ready`  in  1  consumer accepts the response.
- `rsp_data`  out  CHAINW  readback of the previous chain contents.
- `ring_out`  out  RINGW  ring drive:
  - [0] sdata
  - [1] sclk
  - [2] update
  - [RINGW-1:3] always 0
- `ring_in`  in  RINGW  ring return; only [3] (sdata from the chain end) is used, the rest is ignored.

## Operation
- States: IDLE, SLO, SHI, UPD, DONE.
- IDLE:
  - `req_ready`=1.
  - When `req_valid`&`req_ready`: load the shift register from `req_data`, set bitcnt=0, divcnt=0, go to SLO.
- SLO:
  - sclk=0; sdata=shreg[0].
  - Lasts CLKDIV cycles.
  - In its last cycle, capture `ring_in[3]` into rdbk[bitcnt].
  - Then go to SHI.
- SHI:
  - sclk=1; sdata is held.
  - Lasts CLKDIV cycles.
  - In its last cycle, shift shreg right by one and increment bitcnt.
  - If bitcnt==CHAINW-1, go to UPD; otherwise go to SLO.
- UPD:
  - update=1, sclk=0, sdata=0.
  - Lasts CLKDIV cycles, then go to DONE.
- DONE:
  - `rsp_valid`=1 and `rsp_data`=rdbk, both held stable until `rsp_ready`.
  - On handshake, go to IDLE.
  - `req_ready`=0 here and in all states other than IDLE.
- `req_data` is sampled only at acceptance; later changes have no effect.
- Counters:
  - divcnt is $clog2(CLKDIV+1) bits and wraps to 0 at each phase change.
  - bitcnt is $clog2(CHAINW+1) bits.
- Reset (async, any state, including mid-shift):
  - state=IDLE.
  - `ring_out`=0, `rsp_valid`=0, `rsp_data`=0, `req_ready`=0 while `nreset`=0, then 1 from the first clock edge after release.
  - update is not pulsed on an aborted shift, so the cells keep their last applied configuration.

## Timing
- Reset values of all outputs: 0.
- All ring outputs are registered, with no combinational path from `ring_in` to any output.
- Accept at edge E0:
  - first SLO cycle is E0+1.
  - bit i has sclk rising at E0+1+(2i+1)·CLKDIV.
  - update high during cycles E0+1+2·CHAINW·CLKDIV … +CLKDIV−1.
  - `rsp_valid` rises at E0+1+(2·CHAINW+1)·CLKDIV.
- sdata is stable for CLKDIV cycles on each side of every sclk rising edge.
- Throughput: one operation per (2·CHAINW+1)·CLKDIV+2 cycles when `rsp_ready` is tied high.
- The chain is not back-to-back pipelined; a new request is accepted only in IDLE.

## Configuration
- `LA_IORING_CFG_READBACK_EN`
  - Defined: rdbk is captured as described and returned on `rsp_data`.
  - Undefined: no capture register is built, `ring_in` is unused, and `rsp_data` is constant 0. `rsp_valid`/`rsp_ready` still mark completion with identical timing.

## Test plan
- Shift timing: CHAINW=8, CLKDIV=2, send 0xA5 →
  - sdata per bit is 1,0,1,0,0,1,0,1.
  - sclk rises at E0+3, +7, … +31.
  - update is high at E0+33..34.
  - `rsp_valid` at E0+35.
- Chain readback: connect an 8-bit behavioural shift-register chain model. Write 0xA5, then 0x3C → the second `rsp_data`=0xA5 and the model's update latch holds 0x3C.
- Response backpressure: hold `rsp_ready`=0 for 5 cycles in DONE → `rsp_valid` and `rsp_data` stay stable, `req_ready`=0, and a `req_valid` pulse is ignored.
- Reset mid-shift: assert `nreset` after bit 3 →
  - all outputs go to 0 immediately and update is never pulsed.
  - the model latch keeps its prior value.
  - `req_ready`=1 one cycle after release.
- CLKDIV=1, CHAINW=1, send 1 →
  - sclk high at E0+2, update at E0+3, `rsp_valid` at E0+4.
- Build without `LA_IORING_CFG_READBACK_EN`, rerun the chain readback scenario → `rsp_data`=0 on every response, with timing unchanged.
